// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding a shared external arithmetic-right-shift unit; one result register.
// Latency 1 cycle grant->out_valid; no grant while the result is held and out_ready is low.
module shift_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [5*NREQ-1:0]    req_shift,
    input  logic [NREQ-1:0]      req_round,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          shf_a,
    output logic [4:0]           shf_b,
    input  logic [31:0]          shf_y,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    data_q, data_d;

    logic           can_issue;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   scan_idx;
    logic [31:0]    sel_data;
    logic [4:0]     sel_shift;
    logic           sel_round;
    logic [31:0]    rnd_inc;
    logic [32:0]    rnd_sum;
    logic [31:0]    rnd_data;

    // rst_n gates the grant so nothing is consumed while the block is held in reset.
    assign can_issue = rst_n && !clr && ((state_q == EMPTY) || out_ready);

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ))
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            if (!gnt_vld && req_valid[scan_idx[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx[IDW-1:0];
            end
        end
        if (!can_issue)
            gnt_vld = 1'b0;
    end

    assign sel_data  = req_data[32*int'(gnt_idx) +: 32];
    assign sel_shift = req_shift[5*int'(gnt_idx) +: 5];
    assign sel_round = req_round[gnt_idx];

    // Only a non-negative operand can overflow when adding a positive half-LSB.
    always_comb begin
        rnd_inc  = 32'd1 << (sel_shift - 5'd1);
        rnd_sum  = {sel_data[31], sel_data} + {1'b0, rnd_inc};
        rnd_data = rnd_sum[31:0];
        if (!sel_data[31] && rnd_sum[31])
            rnd_data = 32'h7FFF_FFFF;
    end

    always_comb begin
        req_ready = '0;
        shf_a     = '0;
        shf_b     = '0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
            shf_a = (sel_round && (sel_shift != 5'd0)) ? rnd_data : sel_data;
            shf_b = sel_shift;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        if (clr) begin
            state_d = EMPTY;
            ptr_d   = '0;
        end else if (gnt_vld) begin
            state_d = FULL;
            data_d  = shf_y;
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed check of shift_arbiter against a behavioural reference model.
module tb_shift_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic [NREQ-1:0]   req_valid;
    logic [32*NREQ-1:0] req_data;
    logic [5*NREQ-1:0] req_shift;
    logic [NREQ-1:0]   req_round;
    logic [NREQ-1:0]   req_ready;
    logic [31:0]       shf_a;
    logic [4:0]        shf_b;
    logic [31:0]       shf_y;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [IDW-1:0]    out_id;
    logic              out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the result register and pointer must hold.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_id;
    int          m_ptr;

    shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .req_valid(req_valid), .req_data(req_data), .req_shift(req_shift),
        .req_round(req_round), .req_ready(req_ready),
        .shf_a(shf_a), .shf_b(shf_b), .shf_y(shf_y),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready)
    );

    // External shifter.
    assign shf_y = $signed(shf_a) >>> shf_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [31:0] pre_shift(input logic [31:0] d, input int s, input bit r);
        longint v;
        v = longint'($signed(d));
        if (r && s > 0) v = v + (longint'(1) << (s - 1));
        if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
        return v[31:0];
    endfunction

    function automatic logic [31:0] descale(input logic [31:0] a, input int s);
        longint v;
        v = longint'($signed(a));
        v = v >>> s;
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        int          g;
        bit          can;
        logic [31:0] ea;
        logic [NREQ-1:0] er;
        if (!rst_n) begin
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("out_data", out_data, m_data);
                chk("out_id", 32'(out_id), 32'(m_id));
            end
            can = !clr && (!m_valid || out_ready);
            g   = can ? pick(req_valid, m_ptr) : -1;
            er  = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            if (g >= 0) begin
                ea = pre_shift(req_data[32*g +: 32], int'(req_shift[5*g +: 5]), req_round[g]);
                chk("shf_a", shf_a, ea);
                chk("shf_b", 32'(shf_b), 32'(req_shift[5*g +: 5]));
            end else begin
                chk("shf_a_idle", shf_a, 32'd0);
                chk("shf_b_idle", 32'(shf_b), 32'd0);
            end
            if (clr) begin
                m_valid = 1'b0;
                m_ptr   = 0;
            end else if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = descale(ea, int'(req_shift[5*g +: 5]));
                m_id    = g;
                m_ptr   = (g + 1) % NREQ;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic one_shot(input string nm, input logic [31:0] d, input logic [4:0] s,
                            input bit r, input logic [31:0] exp);
        req_valid = 4'b0001;
        req_data[31:0] = d;
        req_shift[4:0] = s;
        req_round[0]   = r;
        @(posedge clk); #1;
        req_valid = '0;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_data"}, out_data, exp);
        chk({nm, "_id"}, 32'(out_id), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_data[32*i +: 32] = $urandom;
            req_shift[5*i +: 5]  = 5'($urandom_range(0, 31));
            req_round[i]         = 1'($urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; out_ready = 1'b1;
        req_valid = '0; req_data = '0; req_shift = '0; req_round = '0;
        #2;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_id", 32'(out_id), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        one_shot("basic", 32'hFFFF_FF00, 5'd4, 1'b0, 32'hFFFF_FFF0);
        one_shot("round_up", 32'h0000_000B, 5'd2, 1'b1, 32'h0000_0003);
        one_shot("round_off", 32'h0000_000B, 5'd2, 1'b0, 32'h0000_0002);
        one_shot("round_sat", 32'h7FFF_FFFF, 5'd1, 1'b1, 32'h3FFF_FFFF);

        // Fairness from a cleared pointer.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        rand_ops();
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("fair_valid", 32'(out_valid), 32'd1);
            chk("fair_id", 32'(out_id), 32'(i % NREQ));
        end

        // Backpressure holds the last result (id 3) and blocks grants.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_id", 32'(out_id), 32'd3);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        chk("bp_next_id", 32'(out_id), 32'd0);
        chk("bp_next_valid", 32'(out_valid), 32'd1);

        // Flush dominates out_ready and pending requests.
        clr = 1'b1;
        #1 chk("clr_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("clr_valid", 32'(out_valid), 32'd0);
        clr = 1'b0;
        #1 chk("clr_regrant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        chk("clr_next_id", 32'(out_id), 32'd0);

        // Asynchronous reset mid-stream, then clean restart.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_id", 32'(out_id), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_id", 32'(out_id), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rand_ops();
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 99) < 3);
        end
        @(posedge clk); #1;
        req_valid = '0; clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the arithmetic-right-shift unit; legal values 2..8.
REQ-002 Parameter IDW, default 2, requester ID width; SHALL equal ceil(log2(NREQ)).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 clr  input  1  synchronous flush; discards the held result and resets the arbitration pointer.
REQ-006 req_valid  input  NREQ  per-requester request strobe.
REQ-007 req_data  input  32*NREQ  signed operand; requester i uses bits [32*i+31 : 32*i].
REQ-008 req_shift  input  5*NREQ  shift amount 0..31; requester i uses bits [5*i+4 : 5*i].
REQ-009 req_round  input  NREQ  1 selects round-half-up before the shift.
REQ-010 req_ready  output  NREQ  one-hot or zero grant; requester i is consumed when req_valid[i] and req_ready[i] are both 1 on the same edge.
REQ-011 shf_a  output  32  operand driven to the external shifter.
REQ-012 shf_b  output  5  shift amount driven to the external shifter.
REQ-013 shf_y  input  32  combinational arithmetic-right-shift result of shf_a by shf_b.
REQ-014 out_valid  output  1  result register holds a valid result.
REQ-015 out_data  output  32  descaled result.
REQ-016 out_id  output  IDW  index of the requester that produced out_data.
REQ-017 out_ready  input  1  downstream accepts the result on an edge where out_valid and out_ready are both 1.

Function
REQ-018 Define can_issue = !out_valid || out_ready; while clr is 1, can_issue SHALL be 0.
REQ-019 When can_issue is 1 and req_valid is nonzero, the block SHALL grant exactly one requester: the first valid index at or after ptr, scanning upward modulo NREQ.
REQ-020 req_ready SHALL be combinational; it SHALL be all zero when can_issue is 0 or req_valid is 0.
REQ-021 Rounding: when req_round[g] is 1 and shift s > 0, shf_a SHALL equal req_data + 2^(s-1), saturated to 0x7FFFFFFF on signed overflow; otherwise shf_a SHALL equal req_data unmodified.
REQ-022 shf_b SHALL equal the granted requester's shift; when there is no grant, shf_a and shf_b SHALL be 0.
REQ-023 On a grant edge, out_data SHALL load shf_y, out_id SHALL load g, and out_valid SHALL become 1; latency from grant to out_valid is exactly 1 cycle.
REQ-024 On a grant edge, ptr SHALL become (g+1) mod NREQ; ptr SHALL hold on edges without a grant.
REQ-025 On an out_valid && out_ready edge with no new grant, out_valid SHALL become 0.
REQ-026 When drain and grant occur on the same edge, the register SHALL be overwritten with the new result and out_valid SHALL stay 1, sustaining 1 result per cycle.
REQ-027 While out_valid is 1 and out_ready is 0, out_data and out_id SHALL hold stable and no grant SHALL occur.
REQ-028 Internal FSM states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on a grant.
  - FULL -> FULL on stall, or on drain with grant.
  - FULL -> EMPTY on drain without grant.
  - Any state -> EMPTY on clr.
REQ-029 clr=1 SHALL on the next edge force out_valid=0 and ptr=0, and SHALL suppress any grant in that cycle; it SHALL dominate a simultaneous out_ready.
REQ-030 Requests with req_valid=0 SHALL never be granted, regardless of ptr.

Reset
REQ-031 On rst_n low, the block SHALL immediately clear out_valid, out_data, out_id, and ptr to 0, without waiting for a clock edge.
REQ-032 req_ready SHALL be 0 while rst_n is low; a transaction interrupted by reset SHALL be lost, and nothing SHALL be emitted after reset release.
REQ-033 The first grant after reset release SHALL start scanning from requester 0.

Verification
REQ-034 Single request, no rounding: req0 data=0xFFFFFF00, shift=4, out_ready=1 -> one cycle later out_valid=1, out_data=0xFFFFFFF0, out_id=0.
REQ-035 Rounding: data=0x0000000B, shift=2, round=1 -> out_data=0x00000003; the same with round=0 -> 0x00000002; data=0x7FFFFFFF, shift=1, round=1 -> saturates, out_data=0x3FFFFFFF.
REQ-036 Fairness: all 4 requesters held valid, out_ready=1 -> grants in the order 0,1,2,3,0,1,... with one out_valid pulse per cycle and no gaps.
REQ-037 Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> req_ready all zero, and out_data/out_id stable; on out_ready=1, the held result drains and the next grant lands in the same cycle.
REQ-038 Flush and reset: clr asserted together with out_ready=1 and pending requests -> next cycle out_valid=0 and the next grant goes to requester 0; rst_n pulsed low mid-stream -> outputs 0 asynchronously, then a clean restart.
